delay_probe_ctrl: RTL and testbench
===================================

// Module: delay_probe_ctrl
// PURPOSE
//  Clocked initiator that drives the 2-phase request input (inR) of a bundled-data delay chain
//  (delayNU family) and receives the chain's delayed output (outR).
//  Launches one request transition per measurement and synchronises the returning transition.
//  Reports the round-trip latency in clock cycles, which is used for delay-chain calibration.
//  Sits between the synchronous test/config logic and the asynchronous control path.
// PARAMETERS
//  CNT_W        8    width of latency counter and lat output
//  SYNC_STAGES  2    flops in the ack_i synchroniser (>=2)
//  TIMEOUT      200  WAIT cycles before giving up; legal range 1 .. 2^CNT_W-1
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active-low
//  start      in   1      request a measurement; sampled each cycle
//  req_o      out  1      2-phase request to the chain's inR (registered; toggles once per measurement)
//  ack_i      in   1      chain's outR (asynchronous; synchronised internally)
//  busy       out  1      high from the accepting edge until return to IDLE
//  done       out  1      one-cycle pulse when lat/timeout_o update
//  timeout_o  out  1      last measurement timed out; holds until next accepted start
//  lat        out  CNT_W  last measured latency; holds until next done
// BEHAVIOUR
//  Reset (rst=0 at edge):
//   - req_o=0, all sync flops=0, state=IDLE, cnt=0.
//   - lat=0, done=0, timeout_o=0, busy=0.
//   - Reset mid-measurement aborts it with no done pulse.
//  ack_s: last synchroniser stage. Phase match means ack_s==req_o.
//  FSM IDLE, WAIT, RECOVER:
//   IDLE:
//    - start=1 AND match: req_o<=~req_o, cnt<=0, timeout_o<=0, busy<=1, ->WAIT.
//    - start=1 while mismatched is ignored.
//   WAIT, match:
//    - lat<=cnt, done<=1, busy<=0, ->IDLE.
//   WAIT, mismatch, cnt==TIMEOUT:
//    - lat<=TIMEOUT, timeout_o<=1, done<=1, ->RECOVER.
//   WAIT, mismatch, otherwise:
//    - cnt<=cnt+1 (never exceeds TIMEOUT).
//   RECOVER:
//    - busy stays 1, start ignored.
//    - On match, busy<=0 and ->IDLE; no second done.
//  start while busy is ignored; not queued.
//  Latency:
//   - Zero-delay loop (ack_i follows req_o combinationally): lat=SYNC_STAGES.
//     done is high in the 3rd cycle after the accepting edge when SYNC_STAGES=2.
//   - Each extra full clock of chain delay adds 1 to lat.
//  Only req_o toggles, so the chain always sees clean 2-phase events.
//  done and the lat update coincide. done is never high in two consecutive cycles.
// CONFIGURATION
//  DELAY_PROBE_MINMAX_EN defined:
//   - Adds ports clear_stats (in,1), min_lat (out,CNT_W) and max_lat (out,CNT_W).
//   - Reset or clear_stats=1: min_lat<=all-ones, max_lat<=0.
//   - On each non-timeout done: min_lat<=min(min_lat,cnt) and max_lat<=max(max_lat,cnt).
//   - If clear_stats and a done coincide, clear wins.
//   - Timeouts never update min_lat or max_lat.
//  Not defined: these ports and registers are absent; all other behaviour is identical.
// TESTING
//  T1  rst=0 for 3 cycles, then release.
//      -> req_o=0, busy=0, done=0, lat=0, timeout_o=0.
//  T2  Zero-delay loopback; pulse start for 1 cycle.
//      -> req_o toggles 0->1, one done pulse, lat=2, busy back to 0.
//  T3  ack_i = req_o delayed 5 clocks; run 2 back-to-back measurements.
//      -> lat=7 both times; req_o ends at 0.
//  T4  ack_i held at 0 with TIMEOUT=10.
//      -> done with lat=10 and timeout_o=1; busy stays 1.
//      Then release ack_i to follow req_o -> busy=0; next start clears timeout_o.
//  T5  start held high continuously, plus assert rst=0 while in WAIT.
//      -> one measurement per IDLE visit with no extra req_o toggles.
//      -> reset mid-measurement: no done pulse, all outputs return to reset values.
//  T6  [DELAY_PROBE_MINMAX_EN] latencies 4, 9, 6, then clear_stats, then 5.
//      -> min_lat=4, max_lat=9 before the clear; all-ones/0 after it; then 5/5.

Source files
------------

// File: rtl/delay_probe_ctrl.sv
// Round-trip latency probe for a 2-phase bundled-data delay chain: launches one req_o
// transition per measurement and counts cycles until the synchronised ack returns.
// Optional min/max latency statistics are enabled with `define DELAY_PROBE_MINMAX_EN.
module delay_probe_ctrl #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             req_o,
    input  logic             ack_i,
    output logic             busy,
    output logic             done,
    output logic             timeout_o,
    output logic [CNT_W-1:0] lat
`ifdef DELAY_PROBE_MINMAX_EN
    ,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat
`endif
);

    localparam logic [CNT_W-1:0] L_TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RECOVER
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_tmo;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_lat;
    logic                   w_ack_s;
    logic                   w_match;
    logic                   w_launch;
    logic                   w_finish;
    logic                   w_expire;
    logic                   w_inc;
    logic                   w_release;

    // ack_i is asynchronous to clk; only the last stage is ever looked at
    always_ff @(posedge clk) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], ack_i};
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];
    assign w_match = (w_ack_s == r_req);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_finish  = 1'b0;
        w_expire  = 1'b0;
        w_inc     = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                // a start while the chain is still mid-event would corrupt the 2-phase protocol
                if (start && w_match) begin
                    w_launch = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_match) begin
                    w_finish = 1'b1;
                    w_next   = S_IDLE;
                end else if (r_cnt == L_TMO) begin
                    w_expire = 1'b1;
                    w_next   = S_RECOVER;
                end else begin
                    w_inc = 1'b1;
                end
            end
            S_RECOVER: begin
                if (w_match) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_tmo  <= 1'b0;
            r_lat  <= '0;
        end else begin
            r_done <= w_finish | w_expire;
            if (w_launch) begin
                r_req  <= ~r_req;
                r_cnt  <= '0;
                r_tmo  <= 1'b0;
                r_busy <= 1'b1;
            end
            if (w_inc) r_cnt <= r_cnt + CNT_W'(1);
            if (w_finish) begin
                r_lat  <= r_cnt;
                r_busy <= 1'b0;
            end
            // busy stays high through RECOVER so no new event is launched into a live chain
            if (w_expire) begin
                r_lat <= L_TMO;
                r_tmo <= 1'b1;
            end
            if (w_release) r_busy <= 1'b0;
        end
    end

    assign req_o     = r_req;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timeout_o = r_tmo;
    assign lat       = r_lat;

`ifdef DELAY_PROBE_MINMAX_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;

    always_ff @(posedge clk) begin
        if (!rst || clear_stats) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_finish) begin
            if (r_cnt < r_min) r_min <= r_cnt;
            if (r_cnt > r_max) r_max <= r_cnt;
        end
    end

    assign min_lat = r_min;
    assign max_lat = r_max;
`endif

endmodule

// File: tb/tb_delay_probe_ctrl.sv
// Randomised self-checking bench for delay_probe_ctrl with a behavioural delay-chain model;
// min/max statistics are exercised when DELAY_PROBE_MINMAX_EN is defined.
module tb_delay_probe_ctrl;

    localparam int CW  = 8;
    localparam int SS  = 2;
    localparam int TMO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ack_i;
    logic          req_o;
    logic          busy;
    logic          done;
    logic          timeout_o;
    logic [CW-1:0] lat;
`ifdef DELAY_PROBE_MINMAX_EN
    logic          clear_stats;
    logic [CW-1:0] min_lat;
    logic [CW-1:0] max_lat;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    delay_probe_ctrl #(.CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .busy      (busy),
        .done      (done),
        .timeout_o (timeout_o),
        .lat       (lat)
`ifdef DELAY_PROBE_MINMAX_EN
        ,
        .clear_stats (clear_stats),
        .min_lat     (min_lat),
        .max_lat     (max_lat)
`endif
    );

    always #5 clk = ~clk;

    // Chain model: ack_i is req_o delayed by dly whole clocks, or forced to a constant
    int          dly     = 0;
    logic        frc     = 1'b0;
    logic        frc_val = 1'b0;
    logic [15:0] sr      = '0;

    always @(posedge clk) sr <= {sr[14:0], req_o};

    always_comb begin
        ack_i = req_o;
        if (frc)           ack_i = frc_val;
        else if (dly != 0) ack_i = sr[dly-1];
    end

    int   n_done = 0;
    int   n_dbl  = 0;
    int   n_tog  = 0;
    logic p_done = 1'b0;
    logic p_req  = 1'b0;

    always @(posedge clk) begin
        if (done === 1'b1) begin
            n_done <= n_done + 1;
            if (p_done === 1'b1) n_dbl <= n_dbl + 1;
        end
        if (req_o !== p_req) n_tog <= n_tog + 1;
        p_done <= done;
        p_req  <= req_o;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One measurement with chain delay d; expectation from the latency rule SS + d capped at TMO
    task automatic measure(input int d, input string nm);
        bit   exp_t;
        int   exp_lat;
        int   k;
        int   d0;
        bit   found;
        logic r0;
        exp_t   = (SS + d > TMO);
        exp_lat = exp_t ? TMO : SS + d;
        frc = 1'b0;
        dly = d;
        repeat (16) @(negedge clk);
        r0    = req_o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0    = n_done;
        n_chk++; if (busy !== 1'b1) $display("FAIL %s busy_at_accept got %b exp 1", nm, busy); else n_pass++;
        n_chk++; if (req_o !== ~r0) $display("FAIL %s req_toggle got %b exp %b", nm, req_o, ~r0); else n_pass++;
        n_chk++; if (timeout_o !== 1'b0) $display("FAIL %s tmo_clear got %b exp 0", nm, timeout_o); else n_pass++;
        k = 0;
        found = 1'b0;
        while (!found && k < 4 * TMO) begin
            @(negedge clk);
            k++;
            found = (done === 1'b1);
        end
        n_chk++; if (!found) $display("FAIL %s done_seen got 0 exp 1", nm); else n_pass++;
        if (found) begin
            n_chk++; if (lat !== CW'(exp_lat)) $display("FAIL %s lat got %0d exp %0d", nm, lat, exp_lat); else n_pass++;
            n_chk++; if (timeout_o !== exp_t) $display("FAIL %s timeout_o got %b exp %b", nm, timeout_o, exp_t); else n_pass++;
            n_chk++; if (k != exp_lat + 1) $display("FAIL %s done_cycle got %0d exp %0d", nm, k, exp_lat + 1); else n_pass++;
            n_chk++; if (busy !== exp_t) $display("FAIL %s busy_at_done got %b exp %b", nm, busy, exp_t); else n_pass++;
            @(negedge clk);
            n_chk++; if (done !== 1'b0) $display("FAIL %s done_width got %b exp 0", nm, done); else n_pass++;
            if (exp_t) begin
                k = 0;
                while (busy === 1'b1 && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                n_chk++; if (busy !== 1'b0) $display("FAIL %s recover_busy got %b exp 0", nm, busy); else n_pass++;
            end
            repeat (2) @(negedge clk);
            n_chk++; if (n_done - d0 != 1) $display("FAIL %s done_count got %0d exp 1", nm, n_done - d0); else n_pass++;
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (req_o !== 1'b0) $display("FAIL rst_req got %b exp 0", req_o); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        n_chk++; if (lat !== '0) $display("FAIL rst_lat got %0d exp 0", lat); else n_pass++;
        n_chk++; if (timeout_o !== 1'b0) $display("FAIL rst_tmo got %b exp 0", timeout_o); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || req_o !== 1'b0) $display("FAIL rst_release got busy=%b done=%b req=%b exp 0/0/0", busy, done, req_o); else n_pass++;
    endtask

    task automatic test_zero_delay();
        do_reset();
        measure(0, "zero_delay");
        n_chk++; if (req_o !== 1'b1) $display("FAIL zero_delay_req got %b exp 1", req_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        measure(5, "b2b_1");
        measure(5, "b2b_2");
        n_chk++; if (req_o !== 1'b0) $display("FAIL b2b_req_end got %b exp 0", req_o); else n_pass++;
    endtask

    task automatic test_mismatch_ignored();
        logic r0;
        dly = 0;
        frc_val = ~req_o;
        frc = 1'b1;
        repeat (4) @(negedge clk);
        r0 = req_o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL mismatch_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (req_o !== r0) $display("FAIL mismatch_req got %b exp %b", req_o, r0); else n_pass++;
        frc = 1'b0;
    endtask

    task automatic test_timeout();
        int   k;
        int   d0;
        logic r0;
        do_reset();
        dly = 0;
        frc_val = 1'b0;
        frc = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = n_done;
        k = 0;
        while (done !== 1'b1 && k < 4 * TMO) begin
            @(negedge clk);
            k++;
        end
        n_chk++; if (done !== 1'b1) $display("FAIL tmo_done got %b exp 1", done); else n_pass++;
        n_chk++; if (lat !== CW'(TMO)) $display("FAIL tmo_lat got %0d exp %0d", lat, TMO); else n_pass++;
        n_chk++; if (timeout_o !== 1'b1) $display("FAIL tmo_flag got %b exp 1", timeout_o); else n_pass++;
        repeat (5) @(negedge clk);
        n_chk++; if (busy !== 1'b1) $display("FAIL tmo_busy_hold got %b exp 1", busy); else n_pass++;
        r0 = req_o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++; if (req_o !== r0) $display("FAIL tmo_start_ignored got %b exp %b", req_o, r0); else n_pass++;
        frc = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_chk++; if (busy !== 1'b0) $display("FAIL tmo_release got %b exp 0", busy); else n_pass++;
        n_chk++; if (timeout_o !== 1'b1) $display("FAIL tmo_flag_hold got %b exp 1", timeout_o); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (n_done - d0 != 1) $display("FAIL tmo_done_count got %0d exp 1", n_done - d0); else n_pass++;
        measure(0, "after_tmo");
    endtask

    task automatic test_random();
        measure(8, "edge_no_tmo");
        measure(9, "edge_tmo");
        for (int i = 0; i < 10; i++) measure(int'($urandom_range(0, 11)), "random");
    endtask

    task automatic test_start_held();
        int d;
        int t0;
        int n0;
        int k;
        d = int'($urandom_range(0, 4));
        frc = 1'b0;
        dly = d;
        repeat (16) @(negedge clk);
        t0 = n_tog;
        n0 = n_done;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_chk++; if (lat !== CW'(SS + d)) $display("FAIL held_lat got %0d exp %0d", lat, SS + d); else n_pass++;
            end
        end
        start = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        n_chk++; if (n_tog - t0 != n_done - n0) $display("FAIL held_toggles got %0d exp %0d", n_tog - t0, n_done - n0); else n_pass++;
        n_chk++; if (n_done - n0 < 80 / (SS + d + 2) - 1) $display("FAIL held_rate got %0d exp >= %0d", n_done - n0, 80 / (SS + d + 2) - 1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n0;
        frc = 1'b0;
        dly = 5;
        repeat (16) @(negedge clk);
        n0 = n_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", busy); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (req_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_rst_ctl got req=%b busy=%b done=%b exp 0/0/0", req_o, busy, done); else n_pass++;
        n_chk++; if (lat !== '0 || timeout_o !== 1'b0) $display("FAIL mid_rst_data got lat=%0d tmo=%b exp 0/0", lat, timeout_o); else n_pass++;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++; if (n_done != n0) $display("FAIL mid_no_done got %0d exp %0d", n_done - n0, 0); else n_pass++;
    endtask

`ifdef DELAY_PROBE_MINMAX_EN
    task automatic test_minmax();
        do_reset();
        n_chk++; if (min_lat !== '1 || max_lat !== '0) $display("FAIL mm_reset got %0d/%0d exp 255/0", min_lat, max_lat); else n_pass++;
        measure(2, "mm_4");
        measure(7, "mm_9");
        measure(4, "mm_6");
        n_chk++; if (min_lat !== CW'(4) || max_lat !== CW'(9)) $display("FAIL mm_pre_clear got %0d/%0d exp 4/9", min_lat, max_lat); else n_pass++;
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        n_chk++; if (min_lat !== '1 || max_lat !== '0) $display("FAIL mm_clear got %0d/%0d exp 255/0", min_lat, max_lat); else n_pass++;
        measure(3, "mm_5");
        n_chk++; if (min_lat !== CW'(5) || max_lat !== CW'(5)) $display("FAIL mm_post got %0d/%0d exp 5/5", min_lat, max_lat); else n_pass++;
        measure(10, "mm_tmo");
        n_chk++; if (min_lat !== CW'(5) || max_lat !== CW'(5)) $display("FAIL mm_tmo_ignored got %0d/%0d exp 5/5", min_lat, max_lat); else n_pass++;
    endtask
`endif

    initial begin
        start = 1'b0;
        rst   = 1'b0;
`ifdef DELAY_PROBE_MINMAX_EN
        clear_stats = 1'b0;
`endif
        test_reset();
        test_zero_delay();
        test_back_to_back();
        test_mismatch_ignored();
        test_timeout();
        test_random();
        test_start_held();
        test_reset_mid();
`ifdef DELAY_PROBE_MINMAX_EN
        test_minmax();
`endif
        n_chk++; if (n_dbl != 0) $display("FAIL done_back_to_back got %0d exp 0", n_dbl); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
